step_pacer: RTL and testbench

STEP_PACER -- requirements
Module: step_pacer

---
 rtl/step_pacer.sv | 72 +++++++
 tb/tb_step_pacer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/step_pacer.sv
// Speed-level step pacer: clamps the requested level and emits a one-cycle step
// pulse every BASE_DIV*(5-level) cycles, with pause, stop and a wrapping step count.
module step_pacer #(
   parameter int unsigned BASE_DIV = 5_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  level,
   input  logic        en,
   output logic [2:0]  level_q,
   output logic        step,
   output logic [15:0] step_cnt
);

   localparam int unsigned CNT_W = 32;
   localparam int unsigned LVL_W = 3;
   localparam int unsigned SC_W  = 16;

   // Terminal count (period - 1) for each running level; BASE_DIV*4 fits in 32 bits.
   localparam logic [CNT_W-1:0] LAST_1 = CNT_W'(BASE_DIV * 32'd4 - 32'd1);
   localparam logic [CNT_W-1:0] LAST_2 = CNT_W'(BASE_DIV * 32'd3 - 32'd1);
   localparam logic [CNT_W-1:0] LAST_3 = CNT_W'(BASE_DIV * 32'd2 - 32'd1);
   localparam logic [CNT_W-1:0] LAST_4 = CNT_W'(BASE_DIV - 32'd1);

   logic [LVL_W-1:0] level_c;
   logic [CNT_W-1:0] last_c;
   logic [CNT_W-1:0] cnt;

   // Requested level saturated to the fastest legal speed.
   always_comb begin
      level_c = level;
      if (level > LVL_W'(4)) level_c = LVL_W'(4);
   end

   always_comb begin
      last_c = '0;
      case (level_q)
         LVL_W'(1): last_c = LAST_1;
         LVL_W'(2): last_c = LAST_2;
         LVL_W'(3): last_c = LAST_3;
         LVL_W'(4): last_c = LAST_4;
         default:   last_c = '0;
      endcase
   end

   // A level change restarts the phase and wins over stop, pause and run.
   always_ff @(posedge clk) begin
      if (rst) begin
         level_q  <= '0;
         cnt      <= '0;
         step     <= 1'b0;
         step_cnt <= '0;
      end else begin
         level_q <= level_c;
         step    <= 1'b0;
         if (level_c != level_q) begin
            cnt <= '0;
         end else if (level_q == LVL_W'(0)) begin
            cnt <= '0;
         end else if (!en) begin
            cnt <= cnt;
         end else if (cnt == last_c) begin
            cnt      <= '0;
            step     <= 1'b1;
            step_cnt <= step_cnt + SC_W'(1);
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_step_pacer.sv
// Self-checking bench for step_pacer: table-driven per-cycle vectors with a scoreboard
// queue on a BASE_DIV=2 instance, plus a step_cnt wrap sequence on a BASE_DIV=1 instance.
module tb_step_pacer;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, en;
   logic [2:0]  level, level_q;
   logic        step;
   logic [15:0] step_cnt;

   logic        rst_f, en_f;
   logic [2:0]  level_f, level_q_f;
   logic        step_f;
   logic [15:0] step_cnt_f;

   step_pacer #(.BASE_DIV(2)) dut (
      .clk(clk), .rst(rst), .level(level), .en(en),
      .level_q(level_q), .step(step), .step_cnt(step_cnt)
   );

   step_pacer #(.BASE_DIV(1)) dut_fast (
      .clk(clk), .rst(rst_f), .level(level_f), .en(en_f),
      .level_q(level_q_f), .step(step_f), .step_cnt(step_cnt_f)
   );

   typedef struct {
      logic        rst;
      logic [2:0]  level;
      logic        en;
      logic [2:0]  lq;
      logic        st;
      logic [15:0] sc;
   } vec_t;

   typedef struct {
      logic [2:0]  lq;
      logic        st;
      logic [15:0] sc;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_run  = 0;
   int   n_fail = 0;

   function automatic void add(input logic r, input int lvl, input logic e,
                               input int lq, input logic st, input int sc, input int n);
      vec_t v;
      v.rst   = r;
      v.level = 3'(lvl);
      v.en    = e;
      v.lq    = 3'(lq);
      v.st    = st;
      v.sc    = 16'(sc);
      for (int k = 0; k < n; k++) vecs.push_back(v);
   endfunction

   task automatic check(input string name, input int act, input int req);
      n_run++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   initial begin
      exp_t e;
      logic prev_step;
      int   pulses;

      rst = 1'b1; level = 3'd0; en = 1'b0;
      rst_f = 1'b1; level_f = 3'd0; en_f = 1'b0;

      // Expected outputs after each edge (BASE_DIV = 2).
      // Reset, then level 3 (period 4): pulses 4 edges after the change edge.
      add(1, 3, 1, 0, 0, 0, 2);
      add(0, 3, 1, 3, 0, 0, 4);        // change edge, cnt 1..3
      add(0, 3, 1, 3, 1, 1, 1);
      add(0, 3, 1, 3, 0, 1, 3);
      add(0, 3, 1, 3, 1, 2, 1);
      add(0, 3, 1, 3, 0, 2, 3);
      add(0, 3, 1, 3, 1, 3, 1);
      // Level 7 clamps to 4 (period 2).
      add(0, 7, 1, 4, 0, 3, 2);
      add(0, 7, 1, 4, 1, 4, 1);
      add(0, 7, 1, 4, 0, 4, 1);
      add(0, 7, 1, 4, 1, 5, 1);
      // Level 2 (period 6), switch to 4 at cnt = 5: no pulse on the change edge.
      add(0, 2, 1, 2, 0, 5, 6);
      add(0, 4, 1, 4, 0, 5, 2);
      add(0, 4, 1, 4, 1, 6, 1);
      // Level 1 (period 8), pause five cycles at cnt = 3.
      add(0, 1, 1, 1, 0, 6, 4);
      add(0, 1, 0, 1, 0, 6, 5);
      add(0, 1, 1, 1, 0, 6, 4);        // cnt 4..7
      add(0, 1, 1, 1, 1, 7, 1);
      // Pause exactly on the pulse-due count: pulse deferred until en returns.
      add(0, 1, 1, 1, 0, 7, 7);
      add(0, 1, 0, 1, 0, 7, 1);
      add(0, 1, 1, 1, 1, 8, 1);
      // Stopped: no pulses, step_cnt holds.
      add(0, 0, 1, 0, 0, 8, 11);
      // Reset on a pulse-due edge discards the phase; level nonzero at release.
      add(0, 3, 1, 3, 0, 8, 4);
      add(1, 3, 1, 0, 0, 0, 1);
      add(0, 3, 1, 3, 0, 0, 4);
      add(0, 3, 1, 3, 1, 1, 1);

      @(posedge clk); #1;
      prev_step = 1'b0;
      foreach (vecs[i]) begin
         rst   = vecs[i].rst;
         level = vecs[i].level;
         en    = vecs[i].en;
         e.lq = vecs[i].lq; e.st = vecs[i].st; e.sc = vecs[i].sc;
         sb.push_back(e);
         @(posedge clk); #1;
         if (sb.size() == 0) begin
            check($sformatf("v%0d scoreboard_empty", i), 0, 1);
         end else begin
            e = sb.pop_front();
            check($sformatf("v%0d level_q", i), int'(level_q), int'(e.lq));
            check($sformatf("v%0d step", i), int'(step), int'(e.st));
            check($sformatf("v%0d step_cnt", i), int'(step_cnt), int'(e.sc));
            check($sformatf("v%0d back_to_back", i), int'(step & prev_step), 0);
         end
         prev_step = step;
      end
      check("scoreboard_drained", sb.size(), 0);

      // Wrap sequence: BASE_DIV = 1, level 4 gives a pulse every cycle.
      rst_f = 1'b1; level_f = 3'd4; en_f = 1'b1;
      @(posedge clk); #1;
      check("fast reset level_q", int'(level_q_f), 0);
      check("fast reset step_cnt", int'(step_cnt_f), 0);
      rst_f = 1'b0;
      @(posedge clk); #1;
      check("fast change level_q", int'(level_q_f), 4);
      check("fast change step", int'(step_f), 0);
      pulses = 0;
      for (int k = 0; k < 65535; k++) begin
         @(posedge clk); #1;
         if (step_f) pulses++;
      end
      check("fast pulses", pulses, 65535);
      check("fast step_cnt max", int'(step_cnt_f), 16'hFFFF);
      @(posedge clk); #1;
      check("fast wrap step", int'(step_f), 1);
      check("fast wrap step_cnt", int'(step_cnt_f), 0);
      @(posedge clk); #1;
      check("fast post-wrap step_cnt", int'(step_cnt_f), 1);
      rst_f = 1'b1;
      @(posedge clk); #1;
      check("fast rst step", int'(step_f), 0);
      check("fast rst step_cnt", int'(step_cnt_f), 0);
      check("fast rst level_q", int'(level_q_f), 0);
      rst_f = 1'b0;
      @(posedge clk); #1;
      check("fast restart change step", int'(step_f), 0);
      @(posedge clk); #1;
      check("fast restart step_cnt", int'(step_cnt_f), 1);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
